// File: rtl/player_input_ctrl.sv
// rtl/player_input_ctrl.sv - submit-button synchroniser, debouncer and guess capture/handshake front end
module player_input_ctrl #(
    parameter int GUESS_W         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_GUESSES     = 7,
    parameter int CNT_W           = $clog2(MAX_GUESSES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [GUESS_W-1:0] switches,
    input  logic               btn_submit,
    input  logic               new_round,
    input  logic               guess_ready,
    output logic [GUESS_W-1:0] guess_data,
    output logic               guess_valid,
    output logic [CNT_W-1:0]   guess_count,
    output logic               guesses_exhausted,
    output logic               btn_dropped
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        LOCKED
    } state_t;

    state_t             state, state_n;
    logic               sync1, sync2;
    logic               db, db_d;
    logic [DB_W-1:0]    cnt;
    logic               press;

    logic [GUESS_W-1:0] data_n;
    logic               valid_n;
    logic [CNT_W-1:0]   count_n;
    logic               exhausted_n;
    logic               dropped_n;

    // Debouncer: db follows sync2 only after it has disagreed for DEBOUNCE_CYCLES edges in a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_d  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_submit;
            sync2 <= sync1;
            db_d  <= db;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

    assign press = db & ~db_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            guess_data        <= '0;
            guess_valid       <= 1'b0;
            guess_count       <= '0;
            guesses_exhausted <= 1'b0;
            btn_dropped       <= 1'b0;
        end else begin
            state             <= state_n;
            guess_data        <= data_n;
            guess_valid       <= valid_n;
            guess_count       <= count_n;
            guesses_exhausted <= exhausted_n;
            btn_dropped       <= dropped_n;
        end
    end

    always_comb begin
        state_n     = state;
        data_n      = guess_data;
        valid_n     = guess_valid;
        count_n     = guess_count;
        exhausted_n = guesses_exhausted;
        dropped_n   = 1'b0;

        // new_round wins over everything; a press in that same cycle is swallowed silently.
        if (new_round) begin
            state_n     = IDLE;
            valid_n     = 1'b0;
            count_n     = '0;
            exhausted_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        data_n  = switches;
                        valid_n = 1'b1;
                        state_n = PENDING;
                    end
                end
                PENDING: begin
                    dropped_n = press;
                    if (guess_valid && guess_ready) begin
                        valid_n = 1'b0;
                        count_n = guess_count + CNT_W'(1);
                        if (count_n == CNT_W'(MAX_GUESSES)) begin
                            exhausted_n = 1'b1;
                            state_n     = LOCKED;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                LOCKED: begin
                    dropped_n = press;
                    valid_n   = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_input_ctrl.sv
// tb/tb_player_input_ctrl.sv - directed plus randomized bench against a behavioural model of player_input_ctrl
module tb_player_input_ctrl;

    localparam int GUESS_W = 4;
    localparam int DB      = 4;
    localparam int MAXG    = 2;
    localparam int CNT_W   = $clog2(MAXG + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [GUESS_W-1:0] switches = '0;
    logic               btn_submit = 1'b0;
    logic               new_round = 1'b0;
    logic               guess_ready = 1'b0;
    logic [GUESS_W-1:0] guess_data;
    logic               guess_valid;
    logic [CNT_W-1:0]   guess_count;
    logic               guesses_exhausted;
    logic               btn_dropped;

    player_input_ctrl #(
        .GUESS_W(GUESS_W),
        .DEBOUNCE_CYCLES(DB),
        .MAX_GUESSES(MAXG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .switches(switches),
        .btn_submit(btn_submit),
        .new_round(new_round),
        .guess_ready(guess_ready),
        .guess_data(guess_data),
        .guess_valid(guess_valid),
        .guess_count(guess_count),
        .guesses_exhausted(guesses_exhausted),
        .btn_dropped(btn_dropped)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int drops_seen   = 0;
    int guesses_seen = 0;
    logic prev_valid = 1'b0;

    // Reference model: btn history window, debounced level, and the guess bookkeeping.
    logic               hist[$];
    logic               m_db, m_db_d;
    logic               m_valid, m_exh, m_drop;
    logic [GUESS_W-1:0] m_data;
    int                 m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
        m_db    = 1'b0;
        m_db_d  = 1'b0;
        m_valid = 1'b0;
        m_exh   = 1'b0;
        m_drop  = 1'b0;
        m_data  = '0;
        m_count = 0;
    endtask

    task automatic model_edge();
        logic press, was_pending, all_diff;
        if (!rst_n) begin
            model_reset();
        end else begin
            press = m_db && !m_db_d;
            if (new_round) begin
                m_valid = 1'b0;
                m_count = 0;
                m_exh   = 1'b0;
                m_drop  = 1'b0;
            end else begin
                was_pending = m_valid;
                m_drop = press && (was_pending || m_exh);
                if (press && !was_pending && !m_exh) begin
                    m_valid = 1'b1;
                    m_data  = switches;
                end
                if (was_pending && guess_ready) begin
                    m_valid = 1'b0;
                    m_count++;
                    if (m_count == MAXG) m_exh = 1'b1;
                end
            end
            m_db_d = m_db;
            hist.push_back(btn_submit);
            void'(hist.pop_front());
            // The level flips once the DB samples seen through the two sync stages all disagree with it.
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++) if (hist[i] == m_db) all_diff = 1'b0;
            if (all_diff) m_db = ~m_db;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("valid", 32'(guess_valid), 32'(m_valid));
            chk("data", 32'(guess_data), 32'(m_data));
            chk("count", 32'(guess_count), 32'(m_count));
            chk("exhausted", 32'(guesses_exhausted), 32'(m_exh));
            chk("dropped", 32'(btn_dropped), 32'(m_drop));
            if (btn_dropped === 1'b1) drops_seen++;
            if (guess_valid === 1'b1 && prev_valid !== 1'b1) guesses_seen++;
            prev_valid = guess_valid;
        end
    endtask

    int d0, g0;

    initial begin
        model_reset();
        tick(2);
        chk("rst_valid", 32'(guess_valid), 32'd0);
        chk("rst_data", 32'(guess_data), 32'd0);
        chk("rst_count", 32'(guess_count), 32'd0);
        chk("rst_exh", 32'(guesses_exhausted), 32'd0);
        chk("rst_drop", 32'(btn_dropped), 32'd0);

        rst_n = 1'b1;
        switches = 4'hA;
        btn_submit = 1'b1;
        tick(6);
        chk("precap_valid", 32'(guess_valid), 32'd0);
        tick(1);
        chk("cap_valid_e6", 32'(guess_valid), 32'd1);
        chk("cap_data_e6", 32'(guess_data), 32'hA);
        switches = 4'h3;
        tick(2);
        chk("cap_data_hold", 32'(guess_data), 32'hA);

        guess_ready = 1'b1;
        tick(1);
        guess_ready = 1'b0;
        chk("hs_valid_drop", 32'(guess_valid), 32'd0);
        chk("hs_count1", 32'(guess_count), 32'd1);

        g0 = guesses_seen;
        tick(10);
        chk("held_no_refire", 32'(guesses_seen - g0), 32'd0);

        btn_submit = 1'b0;
        tick(DB + 3);
        btn_submit = 1'b1;
        tick(DB + 3);
        chk("second_valid", 32'(guess_valid), 32'd1);
        chk("second_data", 32'(guess_data), 32'h3);

        switches = 4'h5;
        d0 = drops_seen;
        btn_submit = 1'b0;
        tick(DB + 3);
        btn_submit = 1'b1;
        tick(DB + 3);
        chk("pend_drop_pulses", 32'(drops_seen - d0), 32'd1);
        chk("pend_data_kept", 32'(guess_data), 32'h3);

        guess_ready = 1'b1;
        tick(1);
        guess_ready = 1'b0;
        chk("lock_exh", 32'(guesses_exhausted), 32'd1);
        chk("lock_count", 32'(guess_count), 32'd2);

        btn_submit = 1'b0;
        tick(DB + 3);
        d0 = drops_seen;
        g0 = guesses_seen;
        btn_submit = 1'b1;
        tick(DB + 3);
        chk("lock_drop", 32'(drops_seen - d0), 32'd1);
        chk("lock_no_guess", 32'(guesses_seen - g0), 32'd0);

        new_round = 1'b1;
        tick(1);
        new_round = 1'b0;
        chk("nr_count", 32'(guess_count), 32'd0);
        chk("nr_exh", 32'(guesses_exhausted), 32'd0);
        tick(4);
        chk("nr_held_no_fire", 32'(guess_valid), 32'd0);

        btn_submit = 1'b0;
        tick(DB + 3);
        switches = 4'h9;
        btn_submit = 1'b1;
        tick(DB + 3);
        chk("nr_capture_valid", 32'(guess_valid), 32'd1);
        chk("nr_capture_data", 32'(guess_data), 32'h9);

        guess_ready = 1'b1;
        new_round = 1'b1;
        tick(1);
        guess_ready = 1'b0;
        new_round = 1'b0;
        chk("coll_count", 32'(guess_count), 32'd0);
        chk("coll_valid", 32'(guess_valid), 32'd0);

        btn_submit = 1'b0;
        tick(DB + 3);
        g0 = guesses_seen;
        repeat (5) begin
            btn_submit = 1'b1;
            tick(3);
            btn_submit = 1'b0;
            tick(3);
        end
        chk("bounce_none", 32'(guesses_seen - g0), 32'd0);
        btn_submit = 1'b1;
        tick(DB + 6);
        chk("bounce_one", 32'(guesses_seen - g0), 32'd1);

        repeat (500) begin
            btn_submit = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) begin
                switches    = GUESS_W'($urandom);
                guess_ready = ($urandom_range(0, 2) == 0);
                new_round   = ($urandom_range(0, 39) == 0);
                rst_n       = ($urandom_range(0, 299) != 0);
                tick(1);
            end
        end
        rst_n = 1'b1;
        new_round = 1'b0;
        guess_ready = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/player_input_ctrl.md
# player_input_ctrl

Parametrised front end for the guessing game's player controls. Samples the raw submit button through a two-flop synchroniser and a counter debouncer, then converts each clean press into exactly one captured guess. It offers the guess to the game FSM over a valid/ready handshake, counts accepted guesses and locks out further input once the per-round limit is reached. It sits between the board switches/buttons and the game FSM.

## Interface

- GUESS_W, 4, width of switch bus and captured guess
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced level changes (legal range ≥1)
- MAX_GUESSES, 7, accepted guesses per round before lockout (legal range ≥1)
- CNT_W, $clog2(MAX_GUESSES+1), derived width of the guess counter (not overridden)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- switches  in  GUESS_W  raw player guess, sampled only at capture
- btn_submit  in  1  raw, asynchronous, bouncy submit button
- new_round  in  1  single-cycle pulse from game FSM: clear count/lockout, drop pending guess
- guess_ready  in  1  game FSM can accept a guess
- guess_data  out  GUESS_W  captured guess, stable while guess_valid
- guess_valid  out  1  captured guess pending
- guess_count  out  CNT_W  guesses accepted this round
- guesses_exhausted  out  1  high while locked out
- btn_dropped  out  1  one-cycle pulse: clean press discarded (pending or locked)

## Operation

- Synchroniser: sync1 <= btn_submit; sync2 <= sync1.
- Debouncer:
  - Register db, counter cnt.
  - If sync2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A bounce shorter than DEBOUNCE_CYCLES restarts the count, so no edge is produced.
- Press: press = db & ~db_d, where db_d is db delayed one cycle. Exactly one press per debounced rising edge. A second press requires a debounced release first.
- FSM states:
  - IDLE: on press, guess_data <= switches, guess_valid <= 1, go to PENDING.
  - PENDING: on guess_valid & guess_ready:
    - guess_valid <= 0 and guess_count <= guess_count+1.
    - If the new count == MAX_GUESSES, go to LOCKED with guesses_exhausted <= 1.
    - Otherwise go to IDLE.
    - guess_data holds its last value. Switch changes during PENDING have no effect.
  - LOCKED: guess_valid stays 0.
- A press in PENDING or LOCKED is discarded and pulses btn_dropped for one cycle. This includes a press in the same cycle as a PENDING handshake.
- new_round (any state):
  - Next state is IDLE; guess_count, guesses_exhausted and guess_valid are cleared; guess_data keeps its value.
  - The debouncer is not cleared, so a button held across new_round does not re-fire.
  - A press coincident with new_round is discarded with no btn_dropped pulse.
- Priority: rst_n > new_round > handshake/press.
- guess_count never exceeds MAX_GUESSES.

## Timing

- Reset (rst_n low at an edge): guess_data=0, guess_valid=0, guess_count=0, guesses_exhausted=0, btn_dropped=0. sync1, sync2, db, db_d and cnt are 0; state is IDLE.
- Reset mid-handshake drops the pending guess.
- Press latency:
  - Edge E0 is the first edge sampling btn_submit=1, held stable afterwards.
  - db rises after edge E0+1+DEBOUNCE_CYCLES.
  - guess_valid and guess_data are visible after edge E0+2+DEBOUNCE_CYCLES.
- Release latency: same as press; db falls after edge E0'+1+DEBOUNCE_CYCLES.
- Handshake:
  - A transfer occurs on any edge with guess_valid=1 and guess_ready=1.
  - guess_valid is low the following cycle, and guess_count and guesses_exhausted update on that same edge.
  - guess_ready may be held high permanently; a guess then lives exactly one cycle.
- btn_dropped is high for exactly the one cycle after the edge where the discarded press is registered.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Reset and capture** (DEBOUNCE_CYCLES=4)
  - Stimulus: reset, switches=4'hA, btn_submit high from edge 0, guess_ready=0.
  - Required: all outputs 0 after reset; guess_valid=1 and guess_data=4'hA after edge 6, held stable while switches change to 4'h3.
- **Bounce rejection**
  - Stimulus: btn_submit toggles with a high width of 3 cycles, 5 times, then stays high.
  - Required: no guess_valid during toggling; exactly one guess after the stable high.
- **Handshake and count**
  - Stimulus: guess_ready asserted 2 cycles after guess_valid.
  - Required: guess_valid drops the next cycle; guess_count goes 0→1; held button produces no second guess until a release and new press.
- **Dropped press**
  - Stimulus: second clean press while PENDING.
  - Required: btn_dropped pulses exactly 1 cycle; guess_data unchanged.
- **Lockout and new round** (MAX_GUESSES=2)
  - Stimulus: two accepted guesses, then a third press.
  - Required: guesses_exhausted=1 and guess_count=2 after the second transfer; the third press gives btn_dropped and no guess_valid.
  - Stimulus: new_round pulse.
  - Required: count=0 and exhausted=0, and the next press is captured.
- **Collision**
  - Stimulus: new_round in the same cycle as guess_valid & guess_ready.
  - Required: guess_count=0 and guess_valid=0 afterwards.
